// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcode, field-position and fetch-state definitions for SISC
package sisc_pkg;

    localparam logic [3:0] NOOP   = 4'd0;
    localparam logic [3:0] LOD    = 4'd1;
    localparam logic [3:0] STR    = 4'd2;
    localparam logic [3:0] SWP    = 4'd3;
    localparam logic [3:0] BRA    = 4'd4;
    localparam logic [3:0] BRR    = 4'd5;
    localparam logic [3:0] BNE    = 4'd6;
    localparam logic [3:0] BNR    = 4'd7;
    localparam logic [3:0] ALU_OP = 4'd8;
    localparam logic [3:0] HLT    = 4'd9;

    localparam logic [3:0] AM_IMM = 4'h8;

    localparam int FIELD_W = 4;
    localparam int IMM_W   = 16;
    localparam int OPC_LSB = 28;
    localparam int MM_LSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_branch_eval.sv
// rtl/sisc_branch_eval.sv - combinational branch condition and target evaluation
module sisc_branch_eval
    import sisc_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [3:0]       opcode_i,
    input  logic [3:0]       mm_i,
    input  logic [3:0]       stat_i,
    input  logic [AW-1:0]    pc_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic             taken_o,
    output logic [AW-1:0]    target_o
);

    logic                    cond;
    logic signed [IMM_W-1:0] imm_sgn;
    logic [AW-1:0]           abs_target;
    logic [AW-1:0]           rel_target;

    // pc_i is already the branch address plus one, so relative targets use it directly
    assign cond       = |(stat_i & mm_i);
    assign imm_sgn    = imm_i;
    assign abs_target = AW'(imm_i);
    assign rel_target = pc_i + AW'(imm_sgn);

    always_comb begin
        taken_o  = 1'b0;
        target_o = pc_i;
        case (opcode_i)
            BRA: begin taken_o = cond;  target_o = abs_target; end
            BRR: begin taken_o = cond;  target_o = rel_target; end
            BNE: begin taken_o = !cond; target_o = abs_target; end
            BNR: begin taken_o = !cond; target_o = rel_target; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - PC/IR holder, instruction fetch handshake and branch resolution
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             fetch_start,
    input  logic             br_eval,
    input  logic [3:0]       stat,
    output logic             im_req,
    output logic [AW-1:0]    im_addr,
    input  logic [DW-1:0]    im_rdata,
    input  logic             im_ack,
    output logic             busy,
    output logic             ir_valid,
    output logic [3:0]       opcode,
    output logic [3:0]       mm,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [3:0]       rt,
    output logic [IMM_W-1:0] imm,
    output logic [AW-1:0]    pc_out,
    output logic             br_taken
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          br_taken_q, br_taken_d;
    logic          br_hit;
    logic [AW-1:0] br_target;

    assign opcode = ir_q[OPC_LSB +: FIELD_W];
    assign mm     = ir_q[MM_LSB  +: FIELD_W];
    assign rd     = ir_q[RD_LSB  +: FIELD_W];
    assign rs     = ir_q[RS_LSB  +: FIELD_W];
    assign rt     = ir_q[RT_LSB  +: FIELD_W];
    assign imm    = ir_q[IMM_LSB +: IMM_W];

    assign im_req   = (state_q == F_REQ);
    assign busy     = (state_q == F_REQ);
    assign ir_valid = (state_q == F_DONE);
    assign im_addr  = pc_q;
    assign pc_out   = pc_q;
    assign br_taken = br_taken_q;

    sisc_branch_eval #(.AW(AW)) u_branch_eval (
        .opcode_i (opcode),
        .mm_i     (mm),
        .stat_i   (stat),
        .pc_i     (pc_q),
        .imm_i    (imm),
        .taken_o  (br_hit),
        .target_o (br_target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        br_taken_d = 1'b0;
        case (state_q)
            F_IDLE: if (fetch_start) state_d = F_REQ;
            F_REQ: begin
                if (im_ack) begin
                    ir_d    = im_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = F_DONE;
                end
            end
            F_DONE: begin
                // a simultaneous fetch_start fetches from the branch target
                if (br_eval && br_hit) begin
                    pc_d       = br_target;
                    br_taken_d = 1'b1;
                end
                if (fetch_start) state_d = F_REQ;
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= F_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            br_taken_q <= br_taken_d;
        end
    end

endmodule
